// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe -- pipelined ripple-carry adder/subtractor with valid/ready flow
// control, for the floating-point datapath (nroot, mantissa, exponent paths).
//
// The WIDTH-bit add is split into STAGES segments of SEG = WIDTH/STAGES bits.
// Stage k resolves its segment using the carry registered by stage k-1 and
// passes the still-unresolved upper operand bits along. Latency is STAGES
// cycles, throughput one operation per cycle; empty stages absorb new data
// even while the output is stalled.
//
// Parameters:
//   WIDTH   operand/result width (must be divisible by STAGES)
//   STAGES  number of pipeline segments, 1..WIDTH
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present          in_ready   operand set accepted
//   a, b       operands                     sub        0: a+b+cin, 1: a-b-cin
//   cin        carry-in / borrow-in
//   out_valid  result present               out_ready  consumer accepts
//   sum        result                       cout       MSB carry (sub: 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// Build option:
//   ADDER_PIPE_SAT_EN  when defined, an overflowing result saturates to the
//                      signed limit selected by the MSB of a (final stage).
// -----------------------------------------------------------------------------

module adder_pipe_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module adder_pipe #(
  parameter int unsigned WIDTH  = 48,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  // Per-stage inputs (from the previous stage or the ports) and registered outputs.
  logic [WIDTH-1:0]  w_a_in [STAGES];
  logic [WIDTH-1:0]  w_b_in [STAGES];
  logic [WIDTH-1:0]  w_s_in [STAGES];
  logic [WIDTH-1:0]  w_a_q  [STAGES];
  logic [WIDTH-1:0]  w_b_q  [STAGES];
  logic [WIDTH-1:0]  w_s_q  [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_q;
  logic [STAGES-1:0] w_v_q;
  logic [STAGES-1:0] w_rdy;
  logic              w_ovf_q;
  logic              w_unused_tail;

  // Ready ripples back from the output: a stage may load if it is empty or
  // the stage after it is loading in the same cycle (bubble collapse).
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES-1] = ~w_v_q[STAGES-1] | out_ready;
    for (int unsigned i = STAGES - 1; i > 0; i--) begin
      w_rdy[i-1] = ~w_v_q[i-1] | w_rdy[i];
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_v_q[STAGES-1];
  assign sum       = w_s_q[STAGES-1];
  assign cout      = w_c_q[STAGES-1];
  assign ovf       = w_ovf_q;

  // The last stage has no unresolved operand bits left to forward.
  assign w_unused_tail = ^{w_a_q[STAGES-1], w_b_q[STAGES-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]     w_cy;
    logic [SEG-1:0]   w_seg;
    logic [WIDTH-1:0] w_s_nxt;
    logic [WIDTH-1:0] w_s_ld;
    logic             w_unused;
    logic             r_v;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;

    if (k == 0) begin : g_head
      // Subtract is folded in here: a - b - cin == a + ~b + ~cin.
      assign w_a_in[k] = a;
      assign w_b_in[k] = sub ? ~b : b;
      assign w_c_in[k] = sub ^ cin;
      assign w_v_in[k] = in_valid;
      assign w_s_in[k] = '0;
    end else begin : g_link
      assign w_a_in[k] = w_a_q[k-1];
      assign w_b_in[k] = w_b_q[k-1];
      assign w_c_in[k] = w_c_q[k-1];
      assign w_v_in[k] = w_v_q[k-1];
      assign w_s_in[k] = w_s_q[k-1];
    end

    // Each stage only consumes its own segment (and the MSB in the last one).
    assign w_unused = ^{w_a_in[k], w_b_in[k]};

    assign w_cy[0] = w_c_in[k];
    for (genvar j = 0; j < SEG; j++) begin : g_bit
      adder_pipe_fa u_fa (
        .i_a (w_a_in[k][k*SEG+j]),
        .i_b (w_b_in[k][k*SEG+j]),
        .i_c (w_cy[j]),
        .o_s (w_seg[j]),
        .o_c (w_cy[j+1])
      );
    end

    always_comb begin
      w_s_nxt = w_s_in[k];
      w_s_nxt[k*SEG +: SEG] = w_seg;
    end

    if (k == STAGES - 1) begin : g_last
      logic w_ovf;
      logic r_ovf;

      // Carry into the MSB is the second-to-last carry of this segment.
      assign w_ovf = w_cy[SEG-1] ^ w_cy[SEG];

`ifdef ADDER_PIPE_SAT_EN
      always_comb begin
        w_s_ld = w_s_nxt;
        if (w_ovf) begin
          w_s_ld = w_a_in[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign w_s_ld = w_s_nxt;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_rdy[k]) begin
          r_ovf <= w_ovf;
        end
      end

      assign w_ovf_q = r_ovf;
    end else begin : g_body
      assign w_s_ld = w_s_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
      end else if (w_rdy[k]) begin
        r_v <= w_v_in[k];
        r_c <= w_cy[SEG];
        r_a <= w_a_in[k];
        r_b <= w_b_in[k];
        r_s <= w_s_ld;
      end
    end

    assign w_v_q[k] = r_v;
    assign w_c_q[k] = r_c;
    assign w_a_q[k] = r_a;
    assign w_b_q[k] = r_b;
    assign w_s_q[k] = r_s;
  end

endmodule

// File: tb/tb_adder_pipe.sv
module tb_adder_pipe;

  localparam int unsigned W   = 48;
  localparam int unsigned STG = 4;
  localparam int          NV  = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  adder_pipe #(.WIDTH(W), .STAGES(STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] es;
    logic [W-1:0] es_sat;
    logic         ec;
    logic         eo;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   pushes = 0;
  int   pops   = 0;
  res_t q[$];

  logic         obs_ov;
  logic         obs_acc;
  logic [W-1:0] obs_s;
  logic         obs_c;
  logic         obs_o;
  logic         stalled = 1'b0;
  logic [W-1:0] st_s;
  logic         st_c;
  logic         st_o;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic res_t mdl(input logic [W-1:0] ma, input logic [W-1:0] mb,
                               input logic ms, input logic mc);
    logic [W:0]   full;
    logic [W-1:0] be;
    res_t         r;
    be   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms ? ~mc : mc)};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (ma[W-1] == be[W-1]) && (full[W-1] != ma[W-1]);
`ifdef ADDER_PIPE_SAT_EN
    if (r.o) r.s = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, account for the
  // transfers the next rising edge will perform, end at the next falling edge.
  task automatic tick(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic ts, input logic tc, input logic ordy);
    res_t e;
    in_valid  = v;
    a         = ta;
    b         = tb;
    sub       = ts;
    cin       = tc;
    out_ready = ordy;
    #1;
    obs_ov  = out_valid;
    obs_acc = in_valid && in_ready;
    obs_s   = sum;
    obs_c   = cout;
    obs_o   = ovf;
    if (stalled) begin
      chk_b("stall_valid", out_valid, 1'b1);
      chk_w("stall_sum", sum, st_s);
      chk_b("stall_cout", cout, st_c);
      chk_b("stall_ovf", ovf, st_o);
    end
    chk_b("in_ready", in_ready, !(q.size() == int'(STG) && !out_ready));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got result %h with nothing pending, want none", sum);
      end else begin
        e = q.pop_front();
        pops++;
        chk_w("sb_sum", sum, e.s);
        chk_b("sb_cout", cout, e.c);
        chk_b("sb_ovf", ovf, e.o);
      end
    end
    if (obs_acc) begin
      q.push_back(mdl(ta, tb, ts, tc));
      pushes++;
    end
    stalled = out_valid && !out_ready;
    st_s    = sum;
    st_c    = cout;
    st_o    = ovf;
    @(negedge clk);
  endtask

  vec_t vt[NV];
  int   racc;
  int   n;

  initial begin
    vt[0] = '{48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0};
    vt[1] = '{48'h5, 48'h7, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFE, 48'hFFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[2] = '{48'hA, 48'h3, 1'b1, 1'b1, 48'h6, 48'h6, 1'b1, 1'b0};
    vt[3] = '{48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1};
    vt[4] = '{48'h8000_0000_0000, 48'h1, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b1, 1'b1};
    vt[5] = '{48'h0000_0000_0FFF, 48'h1, 1'b0, 1'b0, 48'h0000_0000_1000, 48'h0000_0000_1000, 1'b0, 1'b0};
    vt[6] = '{48'h0000_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h0001_0000_0000, 48'h0001_0000_0000, 1'b0, 1'b0};
    vt[7] = '{48'h0, 48'h0, 1'b0, 1'b1, 48'h1, 48'h1, 1'b0, 1'b0};
    vt[8] = '{48'h0, 48'h0, 1'b1, 1'b0, 48'h0, 48'h0, 1'b1, 1'b0};
    vt[9] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 1'b0, 48'h0, 48'h8000_0000_0000, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_sum", sum, '0);
    chk_b("rst_cout", cout, 1'b0);
    chk_b("rst_ovf", ovf, 1'b0);
    chk_b("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, with exact latency
    for (int i = 0; i < NV; i++) begin
      logic [W-1:0] exp_s;
`ifdef ADDER_PIPE_SAT_EN
      exp_s = vt[i].es_sat;
`else
      exp_s = vt[i].es;
`endif
      tick(1'b1, vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, 1'b1);
      chk_b("vec_accept", obs_acc, 1'b1);
      for (int c = 1; c <= int'(STG); c++) begin
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        if (c < int'(STG)) begin
          chk_b("vec_early_valid", obs_ov, 1'b0);
        end else begin
          chk_b("vec_latency", obs_ov, 1'b1);
          chk_w("vec_sum", obs_s, exp_s);
          chk_b("vec_cout", obs_c, vt[i].ec);
          chk_b("vec_ovf", obs_o, vt[i].eo);
        end
      end
    end

    // Fill with out_ready low: four accepted, fifth refused, then drain
    for (int i = 0; i < int'(STG); i++) begin
      tick(1'b1, W'(i + 1) << 20, W'(3), 1'b0, 1'b0, 1'b0);
      chk_b("fill_accept", obs_acc, 1'b1);
    end
    tick(1'b1, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0, 1'b0);
    chk_b("fill_refuse", obs_acc, 1'b0);
    chk_b("fill_out_valid", obs_ov, 1'b1);
    tick(1'b1, 48'h1234_5678_9ABC, 48'h1111_1111_1111, 1'b1, 1'b0, 1'b1);
    chk_b("fill_accept_on_drain", obs_acc, 1'b1);
    chk_b("drain_first", obs_ov, 1'b1);
    for (int i = 0; i < int'(STG); i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk_b("drain_consecutive", obs_ov, 1'b1);
    end
    chk_i("fill_queue_empty", q.size(), 0);

    // Random traffic with random backpressure
    racc = 0;
    n    = 0;
    while (racc < 200 && n < 4000) begin
      tick(1'($urandom_range(0, 1)), rnd48(), rnd48(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (obs_acc) racc++;
      n++;
    end
    chk_i("rand_accepted", racc, 200);
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk_i("rand_drained", q.size(), 0);
    chk_i("rand_pop_vs_push", pops, pushes);

    // Asynchronous reset with work in flight
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, W'(5 + i), W'(7), 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    chk_b("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_b("mid_rst_out_valid", out_valid, 1'b0);
    chk_w("mid_rst_sum", sum, '0);
    chk_b("mid_rst_cout", cout, 1'b0);
    chk_b("mid_rst_ovf", ovf, 1'b0);
    chk_b("mid_rst_in_ready", in_ready, 1'b1);
    q.delete();
    stalled = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      chk_b("post_rst_quiet", obs_ov, 1'b0);
    end
    #1;
    chk_b("post_rst_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
